// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - scanner state type, 4x4 key map and key decode helper
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

   // Indexed [row][column]
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[row][col];
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs, clears to zero
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with press/release debounce
// Emits one key_valid strobe per physical press; the held row alone is watched until release.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES   = 4800,
   parameter int BOUNCE_CYCLES = 240000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] R,
   output logic [3:0] C,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CNT_MAX = (SCAN_CYCLES + 2 > BOUNCE_CYCLES) ? SCAN_CYCLES + 2 : BOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   // Two extra dwell cycles let the synchronizer catch up with a freshly driven column
   localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(SCAN_CYCLES + 1);
   localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);

   logic [3:0]       rs;
   scan_state_t      state_q, state_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_q, row_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;
   logic             row_hit;

   sync_2ff #(.WIDTH(4)) u_row_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (R),
      .q     (rs)
   );

   assign row_hit = rs[row_q];

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      cnt_d       = cnt_q + CNT_W'(1);
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      case (state_q)
         SCAN: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d = '0;
               if (rs == 4'b0000) begin
                  col_d = col_q + 2'd1;
               end else begin
                  row_d   = rs[0] ? 2'd0 : rs[1] ? 2'd1 : rs[2] ? 2'd2 : 2'd3;
                  state_d = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: begin
            if (cnt_q == BOUNCE_LAST) begin
               cnt_d = '0;
               if (row_hit) begin
                  key_valid_d = 1'b1;
                  key_code_d  = key_decode(row_q, col_q);
                  key_held_d  = 1'b1;
                  state_d     = HELD;
               end else begin
                  col_d   = col_q + 2'd1;
                  state_d = SCAN;
               end
            end
         end
         HELD: begin
            cnt_d = '0;
            if (!row_hit) state_d = RELEASE;
         end
         RELEASE: begin
            if (row_hit) begin
               cnt_d = '0;
            end else if (cnt_q == BOUNCE_LAST) begin
               cnt_d      = '0;
               key_held_d = 1'b0;
               col_d      = col_q + 2'd1;
               state_d    = SCAN;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = SCAN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         cnt_q       <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign C         = 4'b0001 << col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a strobe scoreboard
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] R;
   logic [3:0] C;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [3:0] keys [4];
   logic [3:0] sb [$];
   int         total = 0;
   int         bad = 0;
   int         pulses = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] hist = 8'h00;
   logic [7:0] mon_exp;
   logic [3:0] exp_c;

   keypad_scanner #(
      .SCAN_CYCLES   (1),
      .BOUNCE_CYCLES (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .R         (R),
      .C         (C),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Pressed key at [row][col] connects the driven column to that row
   always_comb begin
      R = 4'b0000;
      for (int r = 0; r < 4; r++) R[r] = |(keys[r] & C);
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_held(input logic lvl, input string tag);
      int n = 0;
      while (key_held !== lvl && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, {7'b0, key_held}, {7'b0, lvl});
   endtask

   task automatic wait_col(input logic [3:0] col, input string tag);
      int n = 0;
      while (C !== col && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, {4'h0, C}, {4'h0, col});
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1 && key_valid === 1'b1) begin
         check("strobe_gap", {7'b0, prev_valid}, 8'h00);
         if (sb.size() > 0) mon_exp = {4'h0, sb.pop_front()};
         else mon_exp = 8'hFF;
         check("strobe_code", {4'h0, key_code}, mon_exp);
         check("held_on_strobe", {7'b0, key_held}, 8'h01);
         hist   <= {hist[3:0], key_code};
         pulses <= pulses + 1;
      end
      prev_valid <= (reset === 1'b1) && (key_valid === 1'b1);
   end

   initial begin
      for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_c", {4'h0, C}, 8'h01);
      check("rst_valid", {7'b0, key_valid}, 8'h00);
      check("rst_code", {4'h0, key_code}, 8'h00);
      check("rst_held", {7'b0, key_held}, 8'h00);

      reset = 1'b1;
      for (int k = 0; k < 13; k++) begin
         exp_c = 4'b0001 << ((k / 3) % 4);
         check("scan_col", {4'h0, C}, {4'h0, exp_c});
         @(negedge clk);
      end

      sb.push_back(4'h8);
      keys[2][1] = 1'b1;
      wait_held(1'b1, "held_8");
      @(negedge clk);
      check("code_8", {4'h0, key_code}, 8'h08);
      for (int k = 0; k < 6; k++) begin
         check("c_frozen_8", {4'h0, C}, 8'h02);
         @(negedge clk);
      end
      keys[2][1] = 1'b0;
      wait_held(1'b0, "release_8");
      check("pulses_8", 8'(pulses), 8'd1);

      sb.push_back(4'h6);
      keys[1][2] = 1'b1;
      wait_held(1'b1, "held_6");
      @(negedge clk);
      check("code_6", {4'h0, key_code}, 8'h06);
      check("hist_86", hist, 8'h86);
      keys[0][2] = 1'b1;
      repeat (20) @(negedge clk);
      check("second_key_pulses", 8'(pulses), 8'd2);
      check("second_key_held", {7'b0, key_held}, 8'h01);
      check("second_key_code", {4'h0, key_code}, 8'h06);
      keys[1][2] = 1'b0;
      keys[0][2] = 1'b0;
      wait_held(1'b0, "release_6");

      wait_col(4'b1000, "bounce_col");
      for (int k = 0; k < 10; k++) begin
         keys[0][3] = ~keys[0][3];
         @(negedge clk);
      end
      keys[0][3] = 1'b0;
      repeat (30) @(negedge clk);
      check("bounce_pulses", 8'(pulses), 8'd2);
      check("bounce_code", {4'h0, key_code}, 8'h06);
      check("bounce_held", {7'b0, key_held}, 8'h00);

      sb.push_back(4'hE);
      keys[3][0] = 1'b1;
      wait_held(1'b1, "held_e");
      @(negedge clk);
      check("code_e", {4'h0, key_code}, 8'h0E);
      check("hist_6e", hist, 8'h6E);
      keys[3][0] = 1'b0;
      wait_held(1'b0, "release_e");

      // Land in the middle of the debounce window, then pull reset off-edge
      wait_col(4'b0001, "pre5_col0");
      keys[1][1] = 1'b1;
      wait_col(4'b0010, "pre5_col1");
      repeat (4) @(negedge clk);
      check("pre_reset_pulses", 8'(pulses), 8'd3);
      #2 reset = 1'b0;
      #1;
      check("async_c", {4'h0, C}, 8'h01);
      check("async_code", {4'h0, key_code}, 8'h00);
      check("async_valid", {7'b0, key_valid}, 8'h00);
      check("async_held", {7'b0, key_held}, 8'h00);
      repeat (2) @(negedge clk);
      sb.push_back(4'h5);
      reset = 1'b1;
      wait_held(1'b1, "held_5");
      repeat (10) @(negedge clk);
      check("pulses_5", 8'(pulses), 8'd4);
      check("code_5", {4'h0, key_code}, 8'h05);
      keys[1][1] = 1'b0;
      wait_held(1'b0, "release_5");
      repeat (5) @(negedge clk);
      check("sb_empty", 8'(sb.size()), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and debounces key presses.
- For each debounced press, emits a single-cycle strobe carrying the 4-bit hex code of the key.
- Sits directly upstream of the two-digit display history register inside top, and is the consumer of the board row/column pins.
- Guarantees one strobe per physical press: a held key, contact bounce, or a second key pressed during a hold produces no further strobes.

Parameters:
SCAN_CYCLES, 4800, base column dwell in clk cycles (testbench uses 1)
BOUNCE_CYCLES, 240000, debounce window in clk cycles for press and release (testbench uses 3)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
R  input  4  keypad row lines, asynchronous; a bit reads 1 when a key in the driven column is pressed
C  output  4  keypad column drive, one-hot, active-high
key_code  output  4  hex value of the last accepted key, held until the next accept
key_valid  output  1  one-cycle strobe on acceptance of a key
key_held  output  1  high from acceptance until release debounce completes

Behaviour:
- Reset (reset=0, asynchronous):
  - state SCAN, column index 0, C=4'b0001.
  - key_code=0, key_valid=0, key_held=0.
  - Counters and synchronizer flops cleared.
- R passes through a 2-flop synchronizer before any use. FSM logic sees rs (the synchronized R), 2 cycles late.
- Key map, indexed by [row bit][column bit]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- SCAN:
  - C drives the current column.
  - Dwell per column is SCAN_CYCLES+2 cycles; rs is sampled on the last dwell cycle only.
  - If rs==0 at the sample: advance the column (3 wraps to 0) and restart the dwell.
  - If rs!=0 at the sample: latch the column and the lowest-index set row bit, freeze C, go to DEBOUNCE with the counter cleared.
- DEBOUNCE:
  - Counts BOUNCE_CYCLES cycles.
  - If the latched row bit is still 1 on the final count cycle: key_valid=1 for exactly one cycle, key_code updated in that same cycle, key_held=1, go to HELD.
  - Otherwise: return to SCAN at the next column, with no strobe and key_code unchanged.
- HELD:
  - C stays frozen; only the latched row bit is monitored.
  - Other keys, including a second key in the same column on another row, are ignored.
  - When the latched row bit reads 0, go to RELEASE with the counter cleared.
- RELEASE:
  - The latched row bit must read 0 for BOUNCE_CYCLES consecutive cycles; any 1 restarts the count.
  - On completion: key_held=0, go to SCAN at the next column.
- Latency from a clean, stable press being sampled in SCAN to key_valid: BOUNCE_CYCLES+1 cycles.
- key_valid never asserts in two consecutive cycles.
- Reset asserted mid-operation aborts any state immediately. A key still held after reset release is re-detected and strobed once.
- Multiple rows set at the sample point: the lowest row index wins.

Decomposition:
- Package keypad_pkg holds:
  - the state enum scan_state_t {SCAN, DEBOUNCE, HELD, RELEASE};
  - the 4x4 key map constant;
  - a decode function from (row index, column index) to the 4-bit code.
- Sub-module sync_2ff (parameterized width, reset to 0) for the R synchronizer.
- Counters stay inline. One counter is shared by dwell, debounce and release; its width is $clog2 of the larger of SCAN_CYCLES+2 and BOUNCE_CYCLES, plus 1.

Test Plan (SCAN_CYCLES=1, BOUNCE_CYCLES=3, 10-tick clock):
- Reset low, R=0 → C=0001, key_valid=0, key_code=0. After release, C cycles 0001→0010→0100→1000→0001, 3 cycles per column.
- Hold R=0100 whenever C=0010 → exactly one key_valid pulse with key_code=8, key_held=1. C stays 0010 while held.
- Release, wait for key_held=0, then assert R=0010 whenever C=0100 → one pulse, key_code=6. The downstream stage shows 6 over 8.
- Bounce: toggle R=0001 on C=1000 every cycle for 10 cycles, then R=0 → no key_valid, key_code stays 6.
- While key 6 is held, also assert row0 in column 2 (key 3) → no new strobe. After full release, press R=1000 on C=0001 → key_code=E.
- Drop reset mid-DEBOUNCE → outputs return to reset values asynchronously. With the key still held after reset release, exactly one strobe follows.
